stream_rr_arbiter: RTL and testbench

- N-input valid/ready stream arbiter that shares one registered output stage among NUM_REQ requesters.
- Round-robin grant with per-requester burst lock of up to MAX_BURST beats, which amortises switching for streaming sources.
- Output stage is a single-entry register with full-throughput handshake.
- Sits in front of a shared downstream pipeline stage or consumer; tags each output beat with its source index.

---
 rtl/stream_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin valid/ready stream arbiter with per-owner burst lock and a
// single-entry registered output stage that tags each beat with its source.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester valid
//   req_ready  per-requester ready (at most one bit high)
//   req_data   requester i payload in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  output beat valid
//   out_ready  downstream ready
//   out_data   output payload
//   out_src    index of the requester that produced out_data
//   locked     high while a burst owner holds the grant
module stream_rr_arbiter #(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]              out_src,
    output logic                          locked
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_src_q, out_src_d;

    logic                    stage_ready_c;
    logic                    any_valid_c;
    logic                    owner_hold_c;
    logic [IDX_W-1:0]        search_base_c;
    logic [IDX_W-1:0]        rr_sel_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    found_c;
    logic [IDX_W-1:0]        sel_c;
    logic [DATA_WIDTH-1:0]   sel_data_c;
    logic                    accept_c;

    // Grant selection: a live owner wins outright; otherwise round-robin
    // search starting after the pointer (or after an owner that just dropped).
    always_comb begin
        stage_ready_c = !out_valid_q || out_ready;
        any_valid_c   = |req_valid;
        owner_hold_c  = (state_q == ST_LOCKED) && req_valid[owner_q];
        search_base_c = (state_q == ST_LOCKED) ? owner_q : rr_ptr_q;
        rr_sel_c      = search_base_c;
        found_c       = 1'b0;
        idx_c         = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_c = IDX_W'((32'(search_base_c) + k) % NUM_REQ);
            if (!found_c && req_valid[idx_c]) begin
                found_c  = 1'b1;
                rr_sel_c = idx_c;
            end
        end
        sel_c = owner_hold_c ? owner_q : rr_sel_c;

        sel_data_c = '0;
        req_ready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_c == IDX_W'(i)) begin
                sel_data_c   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = !rst && stage_ready_c && any_valid_c;
            end
        end
        accept_c = |(req_valid & req_ready);
    end

    // Output stage and lock bookkeeping for the next cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_src_d   = sel_c;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Owner went quiet: release now, even while the stage is stalled.
        if ((state_q == ST_LOCKED) && !req_valid[owner_q]) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
        end

        if (accept_c) begin
            if (owner_hold_c) begin
                if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                    state_d    = ST_IDLE;
                    rr_ptr_d   = owner_q;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end else if (MAX_BURST == 1) begin
                state_d  = ST_IDLE;
                rr_ptr_d = sel_c;
            end else begin
                state_d    = ST_LOCKED;
                owner_d    = sel_c;
                beat_cnt_d = CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic checked
// against a scoreboard of accepted request beats.
module tb_stream_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid, out_ready, locked;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;

    logic [N-1:0]    req_valid_b, req_ready_b;
    logic [N*DW-1:0] req_data_b;
    logic            out_valid_b, out_ready_b, locked_b;
    logic [DW-1:0]   out_data_b;
    logic [1:0]      out_src_b;

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .locked(locked)
    );

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_data(req_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_src(out_src_b), .locked(locked_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [23:0] seq [N];

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } beat_t;
    beat_t sb[$];
    beat_t mon_e;

    typedef struct {
        int src;
        int cyc;
    } log_t;
    log_t lg[$];

    // Payload of requester i is {i, running sequence number}.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW]   = {8'(i), seq[i]};
            req_data_b[i*DW +: DW] = {8'(i), 24'hABC};
        end
    end

    // Monitor, sampled 1ns before each rising edge.
    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (!rst) begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL onehot_ready got=%b want at most one bit", req_ready);
            end
            if (out_valid && out_ready) begin
                lg.push_back('{int'(out_src), cyc});
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got src=%0d data=%h want no beat", out_src, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_src !== mon_e.src || out_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL sb_beat got src=%0d data=%h want src=%0d data=%h",
                                 out_src, out_data, mon_e.src, mon_e.data);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{2'(i), req_data[i*DW +: DW]});
                    seq[i] = seq[i] + 24'd1;
                end
            end
        end
    end

    task automatic do_reset(input logic [N-1:0] v, input logic [N-1:0] vb);
        @(negedge clk);
        rst = 1'b1;
        req_valid = v;
        req_valid_b = vb;
        out_ready = 1'b1;
        out_ready_b = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        lg.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] s;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        req_valid_b = '0;
        out_ready = 1'b1;
        out_ready_b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_src !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ready=%b ov=%b src=%0d lk=%b want 0000 0 0 0",
                     req_ready, out_valid, out_src, locked);
        end
        @(negedge clk);
        sb.delete();
        lg.delete();
        s = seq[0];
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== {8'd0, s}) begin
            errors++;
            $display("FAIL first_beat got ov=%b src=%0d data=%h want 1 0 %h",
                     out_valid, out_src, out_data, {8'd0, s});
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL first_lock got=%b want=1", locked);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || locked !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midburst_reset got ov=%b lk=%b ready=%b want 0 0 0000",
                     out_valid, locked, req_ready);
        end
    endtask

    task automatic test_round_robin();
        do_reset('1, '0);
        repeat (20) @(negedge clk);
        checks++;
        if (lg.size() < 17) begin
            errors++;
            $display("FAIL rr_count got=%0d want>=17", lg.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                checks++;
                if (lg[k].src != (k / 4) % 4 || lg[k].cyc != lg[0].cyc + k) begin
                    errors++;
                    $display("FAIL rr_seq[%0d] got src=%0d cyc=%0d want src=%0d cyc=%0d",
                             k, lg[k].src, lg[k].cyc, (k / 4) % 4, lg[0].cyc + k);
                end
            end
        end
    endtask

    task automatic test_lock_release();
        int exp_src [7] = '{2, 2, 3, 3, 3, 3, 0};
        do_reset(4'b1100, '0);
        repeat (2) @(negedge clk);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_owner2 got=%b want=1", locked);
        end
        req_valid = 4'b1000;
        repeat (4) @(negedge clk);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_end3 got=%b want=0", locked);
        end
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if (lg.size() < 7) begin
            errors++;
            $display("FAIL release_count got=%0d want>=7", lg.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (lg[k].src != exp_src[k] || lg[k].cyc != lg[0].cyc + k) begin
                    errors++;
                    $display("FAIL release_seq[%0d] got src=%0d cyc=%0d want src=%0d cyc=%0d",
                             k, lg[k].src, lg[k].cyc, exp_src[k], lg[0].cyc + k);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [23:0] s;
        int exp_src [5] = '{0, 0, 0, 0, 1};
        do_reset(4'b0011, '0);
        s = seq[0];
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2;
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== {8'd0, s + 24'd1}
                || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold got ov=%b src=%0d data=%h ready=%b want 1 0 %h 0000",
                         out_valid, out_src, out_data, req_ready, {8'd0, s + 24'd1});
            end
        end
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (lg.size() < 5) begin
            errors++;
            $display("FAIL stall_count got=%0d want>=5", lg.size());
        end else begin
            checks++;
            if (lg[1].cyc - lg[0].cyc != 6) begin
                errors++;
                $display("FAIL stall_gap got=%0d want=6", lg[1].cyc - lg[0].cyc);
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (lg[k].src != exp_src[k]) begin
                    errors++;
                    $display("FAIL stall_seq[%0d] got=%0d want=%0d", k, lg[k].src, exp_src[k]);
                end
            end
        end
    endtask

    task automatic test_burst1();
        logic [1:0] es;
        do_reset('0, 4'b1010);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2;
            es = (k % 2 == 0) ? 2'd1 : 2'd3;
            checks++;
            if (out_valid_b !== 1'b1 || out_src_b !== es || locked_b !== 1'b0
                || out_data_b !== {6'd0, es, 24'hABC}) begin
                errors++;
                $display("FAIL burst1[%0d] got ov=%b src=%0d lk=%b data=%h want 1 %0d 0 %h",
                         k, out_valid_b, out_src_b, locked_b, out_data_b, es, {6'd0, es, 24'hABC});
            end
        end
    endtask

    task automatic test_random();
        do_reset('0, '0);
        repeat (10000) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got pending=%0d ov=%b want 0 0", sb.size(), out_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 24'd0;
        rst = 1'b1;
        req_valid = '0;
        req_valid_b = '0;
        out_ready = 1'b1;
        out_ready_b = 1'b1;
        test_reset();
        test_round_robin();
        test_lock_release();
        test_stall();
        test_burst1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
